cpu_ctrl: RTL and testbench
===========================

# cpu_ctrl

Beat-driven control unit for the multicycle CPU. It sits directly downstream of the beat generator and consumes its one-hot beat vector `t` (T0..T3). Using that vector it fetches an instruction, holds it in the instruction register, and issues per-beat datapath strobes. It also owns the program counter, including branch and halt handling.

## Interface
Parameters:
- `PC_W`, 8: program counter and instruction-memory address width.
- `IR_W`, 16: instruction width. Format is `[15:12]` opcode, `[11:8]` rd, `[7:0]` imm/addr.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-low.
- `t`  in  4  one-hot beat: 0001=T0, 0010=T1, 0100=T2, 1000=T3; 0000=idle.
- `instr`  in  IR_W  instruction-memory read data.
- `imem_ready`  in  1  instruction-memory data valid, sampled in T0.
- `zero_flag`  in  1  ALU zero result, sampled in T3.
- `imem_addr`  out  PC_W  equals `pc` at all times.
- `pc`  out  PC_W  program counter.
- `ir`  out  IR_W  instruction register.
- `rd`  out  4  equals `ir[11:8]`.
- `imm`  out  8  equals `ir[7:0]`; also serves as the data-memory address.
- `alu_op`  out  2  00=ADD, 01=SUB, 10=AND, 11=OR; 00 when not executing.
- `alu_en`  out  1  ALU execute strobe.
- `mem_rd`, `mem_wr`  out  1  data-memory strobes.
- `rf_we`  out  1  register-file write strobe.
- `halted`  out  1  sticky halt flag.
- `illegal`  out  1  sticky flag: an undefined opcode was executed.
- `beat_err`  out  1  sticky flag: a non-one-hot, non-zero `t` was seen.

## Operation
- Opcodes:
  - 0 NOP
  - 1 ADD, 2 SUB, 3 AND, 4 OR
  - 5 LD, 6 ST
  - 7 JMP, 8 JZ
  - F HLT
  - 9..E are illegal; they execute as NOP and set `illegal`.
- State: RUN and HALT.
  - RUN moves to HALT at the edge that ends T3 of a valid HLT.
  - HALT is left only by reset.
- T0: the control unit drives `imem_addr`=`pc`. At the closing edge:
  - if `imem_ready`=1: `ir`<=`instr` and `ivalid`<=1;
  - otherwise: `ivalid`<=0, and `ir` is held.
- T1: decode only. No strobes are asserted.
- T2, when `ivalid`:
  - ALU ops: `alu_en`=1 and `alu_op` is driven from the opcode.
  - LD: `mem_rd`=1.
  - ST: `mem_wr`=1.
- T3, when `ivalid`:
  - `rf_we`=1 for ALU ops and LD.
  - At the closing edge the PC updates:
    - JMP: `pc`<=`imm`.
    - JZ with `zero_flag`=1: `pc`<=`imm`.
    - HLT: `pc` is held.
    - Otherwise: `pc`<=`pc`+1, with modulo 2^PC_W wrap.
- `ivalid`=0 (fetch miss): the whole window is a bubble. No strobes are asserted and `pc` is unchanged, so the same address is refetched at the next T0.
- HALT: all strobes are 0 and `pc`/`ir` are frozen.
- `t`=0000: idle. No strobes and no register updates.
- `t` not one-hot and non-zero: `beat_err`<=1. That cycle is treated as idle.
- Strobes are combinational from `t`, `ir`, `ivalid` and state. Each strobe is high for exactly one cycle per instruction.

## Timing
- Reset (`rst`=0 at posedge): `pc`=0, `ir`=0, `ivalid`=0, state RUN, `halted`=0, `illegal`=0, `beat_err`=0. All strobes read 0 because the upstream `t` is 0000 during reset.
- After reset release, the first T0 arrives one cycle later, matching the beat generator.
- Fetch-to-write latency: `ir` is valid from T1. Execute strobes appear in T2. `rf_we` and the PC update occur in T3. Throughput is one instruction per 4 cycles.
- Reset mid-instruction abandons that instruction; no further strobes are issued for it.
- `illegal` sets at the edge closing T3 of the offending instruction.

## Structure
- Package `cpu_pkg` holds:
  - opcode constants;
  - beat constants T0..T3 and the idle value;
  - field bit positions;
  - the `alu_op` encodings.
- The beat generator must use the same beat constants.
- Sub-module `cpu_decode` is combinational. It maps opcode to {is_alu, is_ld, is_st, is_jmp, is_jz, is_hlt, is_illegal, alu_op}.
- All registers live in `cpu_ctrl`.

## Test plan
- Reset, then beats with `instr`=0x1305 and `imem_ready`=1:
  - `ir`=0x1305 in T1;
  - `alu_en`=1 with `alu_op`=00 in T2 only;
  - `rf_we`=1 in T3 only, with `rd`=3;
  - `pc` goes 0 to 1 after T3.
- JZ 0x8040:
  - with `zero_flag`=1 in T3, `pc`=0x40;
  - repeated with `zero_flag`=0, `pc`=`pc`+1.
  - JMP 0x7022 gives `pc`=0x22.
- `imem_ready`=0 in T0: no strobes in T1–T3 and `pc` unchanged. The next window with `imem_ready`=1 executes normally.
- LD 0x5210 / ST 0x6210:
  - `mem_rd` (LD) or `mem_wr` (ST) is high in T2 only, with `imm`=0x10;
  - `rf_we` is high in T3 for LD only.
- HLT 0xF000 followed by further beats: `halted`=1 after T3, `pc` frozen, no strobes. Reset clears `halted`. With `pc`=0xFF, a NOP wraps `pc` to 0x00.
- Injected `t`=0011: `beat_err`=1 and no strobes. Opcode 0xA: `illegal`=1 and the instruction acts as NOP. Reset asserted during T2 of an ADD: everything clears and no `rf_we` is issued.

Source files
------------

// File: rtl/cpu_pkg.sv
// ============================================================================
//  cpu_pkg : shared constants for the multicycle CPU control path
//  Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    // One-hot beat encodings, shared with the beat generator
    localparam logic [3:0] BEAT_IDLE = 4'b0000;
    localparam logic [3:0] BEAT_T0   = 4'b0001;
    localparam logic [3:0] BEAT_T1   = 4'b0010;
    localparam logic [3:0] BEAT_T2   = 4'b0100;
    localparam logic [3:0] BEAT_T3   = 4'b1000;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_LD  = 4'h5;
    localparam logic [3:0] OP_ST  = 4'h6;
    localparam logic [3:0] OP_JMP = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 8;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } ctrl_state_t;

endpackage

`default_nettype wire

// File: rtl/cpu_decode.sv
// ============================================================================
//  cpu_decode : combinational opcode classifier for cpu_ctrl
//  Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module cpu_decode
    import cpu_pkg::*;
(
    input  logic [3:0] opcode_i,
    output logic       is_alu_o,
    output logic       is_ld_o,
    output logic       is_st_o,
    output logic       is_jmp_o,
    output logic       is_jz_o,
    output logic       is_hlt_o,
    output logic       is_illegal_o,
    output logic [1:0] alu_op_o
);

    always_comb begin
        is_alu_o     = 1'b0;
        is_ld_o      = 1'b0;
        is_st_o      = 1'b0;
        is_jmp_o     = 1'b0;
        is_jz_o      = 1'b0;
        is_hlt_o     = 1'b0;
        is_illegal_o = 1'b0;
        alu_op_o     = ALU_ADD;
        case (opcode_i)
            OP_NOP: ;
            OP_ADD: begin is_alu_o = 1'b1; alu_op_o = ALU_ADD; end
            OP_SUB: begin is_alu_o = 1'b1; alu_op_o = ALU_SUB; end
            OP_AND: begin is_alu_o = 1'b1; alu_op_o = ALU_AND; end
            OP_OR:  begin is_alu_o = 1'b1; alu_op_o = ALU_OR;  end
            OP_LD:  is_ld_o  = 1'b1;
            OP_ST:  is_st_o  = 1'b1;
            OP_JMP: is_jmp_o = 1'b1;
            OP_JZ:  is_jz_o  = 1'b1;
            OP_HLT: is_hlt_o = 1'b1;
            // 9..E fall through as NOP but are flagged
            default: is_illegal_o = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/cpu_ctrl.sv
// ============================================================================
//  cpu_ctrl : beat-driven fetch/decode/execute control unit with PC and halt
//  Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module cpu_ctrl
    import cpu_pkg::*;
#(
    parameter int PC_W = 8,
    parameter int IR_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      t,
    input  logic [IR_W-1:0] instr,
    input  logic            imem_ready,
    input  logic            zero_flag,
    output logic [PC_W-1:0] imem_addr,
    output logic [PC_W-1:0] pc,
    output logic [IR_W-1:0] ir,
    output logic [3:0]      rd,
    output logic [7:0]      imm,
    output logic [1:0]      alu_op,
    output logic            alu_en,
    output logic            mem_rd,
    output logic            mem_wr,
    output logic            rf_we,
    output logic            halted,
    output logic            illegal,
    output logic            beat_err
);

    ctrl_state_t     state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [IR_W-1:0] ir_q, ir_d;
    logic            ivalid_q, ivalid_d;
    logic            illegal_q, illegal_d;
    logic            beat_err_q, beat_err_d;

    logic       dec_alu, dec_ld, dec_st, dec_jmp, dec_jz, dec_hlt, dec_illegal;
    logic [1:0] dec_alu_op;
    logic       run, exec, beat_bad;

    cpu_decode u_decode (
        .opcode_i     (ir_q[OPC_MSB:OPC_LSB]),
        .is_alu_o     (dec_alu),
        .is_ld_o      (dec_ld),
        .is_st_o      (dec_st),
        .is_jmp_o     (dec_jmp),
        .is_jz_o      (dec_jz),
        .is_hlt_o     (dec_hlt),
        .is_illegal_o (dec_illegal),
        .alu_op_o     (dec_alu_op)
    );

    assign run  = (state_q == ST_RUN);
    assign exec = run && ivalid_q;
    // More than one bit set: the cycle is flagged and otherwise ignored
    assign beat_bad = (t != BEAT_IDLE) && ((t & (t - 4'd1)) != 4'd0);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ivalid_d   = ivalid_q;
        illegal_d  = illegal_q;
        beat_err_d = beat_err_q || beat_bad;
        alu_en     = 1'b0;
        alu_op     = ALU_ADD;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        rf_we      = 1'b0;

        if (run && t == BEAT_T0) begin
            ivalid_d = imem_ready;
            if (imem_ready) begin
                ir_d = instr;
            end
        end

        if (exec && t == BEAT_T2) begin
            alu_en = dec_alu;
            alu_op = dec_alu ? dec_alu_op : ALU_ADD;
            mem_rd = dec_ld;
            mem_wr = dec_st;
        end

        if (exec && t == BEAT_T3) begin
            rf_we = dec_alu || dec_ld;
            if (dec_illegal) begin
                illegal_d = 1'b1;
            end
            if (dec_jmp || (dec_jz && zero_flag)) begin
                pc_d = PC_W'(ir_q[IMM_MSB:IMM_LSB]);
            end else if (dec_hlt) begin
                state_d = ST_HALT;
            end else begin
                pc_d = pc_q + PC_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_RUN;
            pc_q       <= '0;
            ir_q       <= '0;
            ivalid_q   <= 1'b0;
            illegal_q  <= 1'b0;
            beat_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ivalid_q   <= ivalid_d;
            illegal_q  <= illegal_d;
            beat_err_q <= beat_err_d;
        end
    end

    assign pc        = pc_q;
    assign imem_addr = pc_q;
    assign ir        = ir_q;
    assign rd        = ir_q[RD_MSB:RD_LSB];
    assign imm       = ir_q[IMM_MSB:IMM_LSB];
    assign halted    = (state_q == ST_HALT);
    assign illegal   = illegal_q;
    assign beat_err  = beat_err_q;

endmodule

`default_nettype wire

// File: tb/tb_cpu_ctrl.sv
// ============================================================================
//  tb_cpu_ctrl : directed self-checking bench for cpu_ctrl
//  Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_cpu_ctrl;

    logic        clk;
    logic        rst;
    logic [3:0]  t;
    logic [15:0] instr;
    logic        imem_ready;
    logic        zero_flag;
    logic [7:0]  imem_addr;
    logic [7:0]  pc;
    logic [15:0] ir;
    logic [3:0]  rd;
    logic [7:0]  imm;
    logic [1:0]  alu_op;
    logic        alu_en, mem_rd, mem_wr, rf_we;
    logic        halted, illegal, beat_err;

    int checks = 0;
    int errors = 0;

    // Per-beat captures of the last window: strobes are {alu_en, mem_rd, mem_wr, rf_we}
    logic [3:0]  obs_strb [4];
    logic [1:0]  obs_op   [4];
    logic [15:0] obs_ir_t1;
    logic [7:0]  obs_imm_t2;
    logic [3:0]  obs_rd_t3;
    logic        obs_ill_t3;

    cpu_ctrl #(.PC_W(8), .IR_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .t          (t),
        .instr      (instr),
        .imem_ready (imem_ready),
        .zero_flag  (zero_flag),
        .imem_addr  (imem_addr),
        .pc         (pc),
        .ir         (ir),
        .rd         (rd),
        .imm        (imm),
        .alu_op     (alu_op),
        .alu_en     (alu_en),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .rf_we      (rf_we),
        .halted     (halted),
        .illegal    (illegal),
        .beat_err   (beat_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; t = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
    endtask

    // Drives T0..T3 then one idle beat so the registered PC is observable
    task automatic window(input logic [15:0] ins, input logic rdy, input logic zf);
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            t = 4'b0001 << b; instr = ins; imem_ready = rdy; zero_flag = zf;
            #1;
            obs_strb[b] = {alu_en, mem_rd, mem_wr, rf_we};
            obs_op[b]   = alu_op;
            if (b == 1) obs_ir_t1 = ir;
            if (b == 2) obs_imm_t2 = imm;
            if (b == 3) begin obs_rd_t3 = rd; obs_ill_t3 = illegal; end
        end
        @(negedge clk);
        t = 4'b0000; imem_ready = 1'b0; zero_flag = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (pc !== 8'h00) begin errors++; $display("FAIL reset_pc got %h exp 00", pc); end
        checks++; if (ir !== 16'h0000) begin errors++; $display("FAIL reset_ir got %h exp 0000", ir); end
        checks++; if ({halted, illegal, beat_err} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {halted, illegal, beat_err}); end
        checks++; if ({alu_en, mem_rd, mem_wr, rf_we} !== 4'b0000) begin errors++; $display("FAIL reset_strb got %b exp 0000", {alu_en, mem_rd, mem_wr, rf_we}); end
        checks++; if (imem_addr !== 8'h00) begin errors++; $display("FAIL reset_addr got %h exp 00", imem_addr); end
    endtask

    task automatic test_add();
        window(16'h1305, 1'b1, 1'b0);
        checks++; if (obs_ir_t1 !== 16'h1305) begin errors++; $display("FAIL add_ir_t1 got %h exp 1305", obs_ir_t1); end
        checks++; if (obs_strb[0] !== 4'b0000 || obs_strb[1] !== 4'b0000) begin errors++; $display("FAIL add_t0t1 got %b %b exp 0000 0000", obs_strb[0], obs_strb[1]); end
        checks++; if (obs_strb[2] !== 4'b1000 || obs_op[2] !== 2'b00) begin errors++; $display("FAIL add_t2 got %b op %b exp 1000 op 00", obs_strb[2], obs_op[2]); end
        checks++; if (obs_strb[3] !== 4'b0001 || obs_op[3] !== 2'b00) begin errors++; $display("FAIL add_t3 got %b op %b exp 0001 op 00", obs_strb[3], obs_op[3]); end
        checks++; if (obs_rd_t3 !== 4'd3) begin errors++; $display("FAIL add_rd got %h exp 3", obs_rd_t3); end
        checks++; if (pc !== 8'h01) begin errors++; $display("FAIL add_pc got %h exp 01", pc); end
        checks++; if (imem_addr !== 8'h01) begin errors++; $display("FAIL add_addr got %h exp 01", imem_addr); end
    endtask

    task automatic test_branch();
        window(16'h8040, 1'b1, 1'b1);
        checks++; if (pc !== 8'h40) begin errors++; $display("FAIL jz_taken_pc got %h exp 40", pc); end
        checks++; if (obs_strb[2] !== 4'b0000 || obs_strb[3] !== 4'b0000) begin errors++; $display("FAIL jz_strb got %b %b exp 0000 0000", obs_strb[2], obs_strb[3]); end
        window(16'h8040, 1'b1, 1'b0);
        checks++; if (pc !== 8'h41) begin errors++; $display("FAIL jz_not_taken_pc got %h exp 41", pc); end
        window(16'h7022, 1'b1, 1'b0);
        checks++; if (pc !== 8'h22) begin errors++; $display("FAIL jmp_pc got %h exp 22", pc); end
    endtask

    task automatic test_fetch_miss();
        window(16'h1305, 1'b0, 1'b0);
        checks++; if (obs_strb[1] !== 4'b0000 || obs_strb[2] !== 4'b0000 || obs_strb[3] !== 4'b0000) begin errors++; $display("FAIL miss_strb got %b %b %b exp all 0000", obs_strb[1], obs_strb[2], obs_strb[3]); end
        checks++; if (pc !== 8'h22) begin errors++; $display("FAIL miss_pc got %h exp 22", pc); end
        checks++; if (ir !== 16'h7022) begin errors++; $display("FAIL miss_ir_held got %h exp 7022", ir); end
        window(16'h2305, 1'b1, 1'b0);
        checks++; if (obs_strb[2] !== 4'b1000 || obs_op[2] !== 2'b01) begin errors++; $display("FAIL sub_t2 got %b op %b exp 1000 op 01", obs_strb[2], obs_op[2]); end
        checks++; if (pc !== 8'h23) begin errors++; $display("FAIL sub_pc got %h exp 23", pc); end
    endtask

    task automatic test_mem();
        window(16'h5210, 1'b1, 1'b0);
        checks++; if (obs_strb[2] !== 4'b0100 || obs_imm_t2 !== 8'h10) begin errors++; $display("FAIL ld_t2 got %b imm %h exp 0100 imm 10", obs_strb[2], obs_imm_t2); end
        checks++; if (obs_strb[3] !== 4'b0001) begin errors++; $display("FAIL ld_t3 got %b exp 0001", obs_strb[3]); end
        window(16'h6210, 1'b1, 1'b0);
        checks++; if (obs_strb[2] !== 4'b0010 || obs_imm_t2 !== 8'h10) begin errors++; $display("FAIL st_t2 got %b imm %h exp 0010 imm 10", obs_strb[2], obs_imm_t2); end
        checks++; if (obs_strb[3] !== 4'b0000) begin errors++; $display("FAIL st_t3 got %b exp 0000", obs_strb[3]); end
        checks++; if (pc !== 8'h25) begin errors++; $display("FAIL mem_pc got %h exp 25", pc); end
    endtask

    task automatic test_illegal();
        window(16'hA000, 1'b1, 1'b0);
        checks++; if (obs_strb[2] !== 4'b0000 || obs_strb[3] !== 4'b0000) begin errors++; $display("FAIL ill_strb got %b %b exp 0000 0000", obs_strb[2], obs_strb[3]); end
        checks++; if (obs_ill_t3 !== 1'b0 || illegal !== 1'b1) begin errors++; $display("FAIL ill_flag got t3 %b after %b exp 0 1", obs_ill_t3, illegal); end
        checks++; if (pc !== 8'h26) begin errors++; $display("FAIL ill_pc got %h exp 26", pc); end
        window(16'h4105, 1'b1, 1'b0);
        checks++; if (obs_strb[2] !== 4'b1000 || obs_op[2] !== 2'b11) begin errors++; $display("FAIL or_t2 got %b op %b exp 1000 op 11", obs_strb[2], obs_op[2]); end
    endtask

    task automatic test_beat_err();
        @(negedge clk);
        t = 4'b0011;
        #1;
        checks++; if ({alu_en, mem_rd, mem_wr, rf_we} !== 4'b0000) begin errors++; $display("FAIL berr_strb got %b exp 0000", {alu_en, mem_rd, mem_wr, rf_we}); end
        @(negedge clk);
        t = 4'b0000;
        #1;
        checks++; if (beat_err !== 1'b1) begin errors++; $display("FAIL berr_flag got %b exp 1", beat_err); end
        checks++; if (pc !== 8'h27 || ir !== 16'h4105) begin errors++; $display("FAIL berr_regs got pc %h ir %h exp 27 4105", pc, ir); end
    endtask

    task automatic test_halt();
        window(16'hF000, 1'b1, 1'b0);
        checks++; if (halted !== 1'b1 || pc !== 8'h27) begin errors++; $display("FAIL hlt got halted %b pc %h exp 1 27", halted, pc); end
        window(16'h1305, 1'b1, 1'b0);
        checks++; if (obs_strb[2] !== 4'b0000 || obs_strb[3] !== 4'b0000) begin errors++; $display("FAIL hlt_strb got %b %b exp 0000 0000", obs_strb[2], obs_strb[3]); end
        checks++; if (pc !== 8'h27 || ir !== 16'hF000) begin errors++; $display("FAIL hlt_frozen got pc %h ir %h exp 27 f000", pc, ir); end
        do_reset();
        checks++; if ({halted, illegal, beat_err} !== 3'b000 || pc !== 8'h00) begin errors++; $display("FAIL hlt_reset got flags %b pc %h exp 000 00", {halted, illegal, beat_err}, pc); end
    endtask

    task automatic test_wrap();
        window(16'h70FF, 1'b1, 1'b0);
        checks++; if (pc !== 8'hFF) begin errors++; $display("FAIL wrap_jmp got %h exp ff", pc); end
        window(16'h0000, 1'b1, 1'b0);
        checks++; if (pc !== 8'h00) begin errors++; $display("FAIL wrap_pc got %h exp 00", pc); end
        checks++; if (obs_strb[2] !== 4'b0000 || obs_strb[3] !== 4'b0000) begin errors++; $display("FAIL nop_strb got %b %b exp 0000 0000", obs_strb[2], obs_strb[3]); end
    endtask

    task automatic test_reset_mid();
        window(16'h7030, 1'b1, 1'b0);
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            t = 4'b0001 << b; instr = 16'h1305; imem_ready = 1'b1;
            #1;
        end
        checks++; if (alu_en !== 1'b1) begin errors++; $display("FAIL mid_t2_alu got %b exp 1", alu_en); end
        rst = 1'b0;
        @(negedge clk);
        t = 4'b0000;
        @(negedge clk);
        rst = 1'b1;
        t = 4'b1000;
        #1;
        checks++; if ({alu_en, mem_rd, mem_wr, rf_we} !== 4'b0000) begin errors++; $display("FAIL mid_t3_strb got %b exp 0000", {alu_en, mem_rd, mem_wr, rf_we}); end
        @(negedge clk);
        t = 4'b0000;
        #1;
        checks++; if (pc !== 8'h00 || ir !== 16'h0000) begin errors++; $display("FAIL mid_regs got pc %h ir %h exp 00 0000", pc, ir); end
    endtask

    initial begin
        rst = 1'b0; t = 4'b0000; instr = 16'h0000; imem_ready = 1'b0; zero_flag = 1'b0;
        test_reset();
        test_add();
        test_branch();
        test_fetch_miss();
        test_mem();
        test_illegal();
        test_beat_err();
        test_halt();
        test_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
